// File: rtl/leitor_cedula_if.sv
// Signal bundle between the note-reader front end and the logic around it.
// The slave side is the reader itself; the master side drives keys and sensors.
interface leitor_cedula_if;
  logic [1:0] SELECAO;
  logic       CONFIRMA;
  logic [1:0] SENSOR_NOTA;
  logic [1:0] SAIDA;
  logic [1:0] PRODUTO;
  logic [1:0] CEDULA;
  logic       TIMER;
  logic       ENTREGA;
  logic       OCUPADO;

  modport master (
    output SELECAO, CONFIRMA, SENSOR_NOTA, SAIDA,
    input  PRODUTO, CEDULA, TIMER, ENTREGA, OCUPADO
  );

  modport slave (
    input  SELECAO, CONFIRMA, SENSOR_NOTA, SAIDA,
    output PRODUTO, CEDULA, TIMER, ENTREGA, OCUPADO
  );
endinterface

// File: rtl/leitor_cedula.sv
// Front end for the payment FSM: latches the product, debounces the note sensor,
// strobes one CEDULA per inserted note and raises TIMER after inactivity.
module leitor_cedula #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000,
  parameter int CW       = 16
) (
  input  logic           CLK,
  input  logic           RST,
  leitor_cedula_if.slave bus
);

  localparam logic [2:0] OCIOSO   = 3'd0;
  localparam logic [2:0] ESPERA   = 3'd1;
  localparam logic [2:0] FILTRO   = 3'd2;
  localparam logic [2:0] RETIRADA = 3'd3;
  localparam logic [2:0] EXPIRADO = 3'd4;

  localparam logic [CW-1:0] DEB_LIM = CW'(DEBOUNCE);
  localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  logic [2:0]    state_q, state_d;
  logic          conf_q, conf_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [CW-1:0] deb_q, deb_d;
  logic [1:0]    code_q, code_d;
  logic [1:0]    produto_q, produto_d;
  logic [1:0]    cedula_q, cedula_d;
  logic          timer_q, timer_d;
  logic          entrega_q, entrega_d;
  logic          ocupado_q, ocupado_d;

  logic          conf_edge, fim, expira, sel_ok;
  logic [CW-1:0] tmo_inc, deb_inc;

  assign conf_edge = bus.CONFIRMA & ~conf_q;
  assign sel_ok    = (bus.SELECAO == 2'b00) || (bus.SELECAO == 2'b11);
  assign fim       = (bus.SAIDA == 2'b10) || (bus.SAIDA == 2'b11);
  assign expira    = (tmo_q >= TMO_LIM);
  assign tmo_inc   = sat_inc(tmo_q);
  assign deb_inc   = sat_inc(deb_q);

  always_comb begin
    state_d   = state_q;
    conf_d    = bus.CONFIRMA;
    tmo_d     = tmo_q;
    deb_d     = deb_q;
    code_d    = code_q;
    produto_d = produto_q;
    cedula_d  = cedula_q;
    timer_d   = timer_q;
    entrega_d = 1'b0;

    // Session end wins over every other transition and drops any pending note.
    if (state_q != OCIOSO && fim) begin
      state_d   = OCIOSO;
      produto_d = 2'b00;
      cedula_d  = 2'b00;
      timer_d   = 1'b0;
      tmo_d     = '0;
      deb_d     = '0;
    end else begin
      case (state_q)
        OCIOSO: begin
          if (conf_edge && sel_ok) begin
            produto_d = bus.SELECAO;
            tmo_d     = '0;
            deb_d     = '0;
            state_d   = ESPERA;
          end
        end
        ESPERA, FILTRO, RETIRADA: begin
          tmo_d = tmo_inc;
          if (expira) begin
            state_d   = EXPIRADO;
            entrega_d = 1'b1;
            timer_d   = 1'b1;
            cedula_d  = 2'b00;
            deb_d     = '0;
          end else if (state_q == ESPERA) begin
            if (bus.SENSOR_NOTA != 2'b00) begin
              code_d = bus.SENSOR_NOTA;
              if (DEBOUNCE <= 1) begin
                state_d   = RETIRADA;
                entrega_d = 1'b1;
                cedula_d  = bus.SENSOR_NOTA;
                timer_d   = 1'b0;
                tmo_d     = '0;
                deb_d     = '0;
              end else begin
                deb_d   = ONE;
                state_d = FILTRO;
              end
            end
          end else if (state_q == FILTRO) begin
            if (bus.SENSOR_NOTA == 2'b00) begin
              deb_d   = '0;
              state_d = ESPERA;
            end else if (bus.SENSOR_NOTA != code_q) begin
              code_d = bus.SENSOR_NOTA;
              deb_d  = ONE;
            end else if (deb_inc >= DEB_LIM) begin
              state_d   = RETIRADA;
              entrega_d = 1'b1;
              cedula_d  = code_q;
              timer_d   = 1'b0;
              tmo_d     = '0;
              deb_d     = '0;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            // One empty-sensor cycle separates consecutive notes.
            if (bus.SENSOR_NOTA == 2'b00) state_d = ESPERA;
          end
        end
        EXPIRADO: begin
          state_d = EXPIRADO;
        end
        default: begin
          state_d = OCIOSO;
        end
      endcase
    end

    ocupado_d = (state_d != OCIOSO);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= OCIOSO;
      conf_q    <= 1'b0;
      tmo_q     <= '0;
      deb_q     <= '0;
      code_q    <= 2'b00;
      produto_q <= 2'b00;
      cedula_q  <= 2'b00;
      timer_q   <= 1'b0;
      entrega_q <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      conf_q    <= conf_d;
      tmo_q     <= tmo_d;
      deb_q     <= deb_d;
      code_q    <= code_d;
      produto_q <= produto_d;
      cedula_q  <= cedula_d;
      timer_q   <= timer_d;
      entrega_q <= entrega_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign bus.PRODUTO = produto_q;
  assign bus.CEDULA  = cedula_q;
  assign bus.TIMER   = timer_q;
  assign bus.ENTREGA = entrega_q;
  assign bus.OCUPADO = ocupado_q;

endmodule

// File: doc/leitor_cedula.md
Name: leitor_cedula

Overview:
- Front-end stage directly upstream of the payment FSM; produces its PRODUTO, CEDULA and TIMER inputs.
- Latches the product selection on a confirm key and debounces the raw note-sensor code.
- Issues one strobed CEDULA code per physically inserted note and runs the inactivity timeout that drives TIMER.
- The payment FSM advances only on cycles where ENTREGA=1, used as its clock enable.

Parameters:
- DEBOUNCE, 4, cycles SENSOR_NOTA must hold a nonzero code unchanged before it is accepted (>=1).
- TIMEOUT, 1000, cycles of inactivity after the last accepted event before TIMER asserts (>=2).
- CW, 16, width of internal counters; must hold max(DEBOUNCE, TIMEOUT).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous reset, active-high.
- SELECAO  input  2  raw product keys: 00 = 2-unit product, 11 = 10-unit product; 01/10 are ignored.
- CONFIRMA  input  1  confirm key, level; sampled on the rising edge of the registered level.
- SENSOR_NOTA  input  2  raw acceptor code: 00 = none, 01 = 2-note, 10 = 5-note, 11 = unrecognised.
- SAIDA  input  2  status fed back from the payment FSM; 10 = incorrect, 11 = paid, both end the session.
- PRODUTO  output  2  latched product code, held for the whole session.
- CEDULA  output  2  accepted note code, valid when ENTREGA=1.
- TIMER  output  1  timeout flag, valid when ENTREGA=1.
- ENTREGA  output  1  one-cycle strobe: CEDULA/TIMER valid for the payment FSM.
- OCUPADO  output  1  high while a session is open (any state except OCIOSO).

Behaviour:
- Reset (async, immediate): state=OCIOSO; PRODUTO=00, CEDULA=00, TIMER=0, ENTREGA=0, OCUPADO=0; all counters=0; CONFIRMA edge register=0.
- All outputs are registered. ENTREGA is never high for two consecutive cycles.
- State OCIOSO:
  - Rising edge of CONFIRMA with SELECAO in {00,11} -> latch PRODUTO=SELECAO, clear the timeout counter, go to ESPERA.
  - SELECAO 01/10 on the edge -> stay in OCIOSO.
  - SENSOR_NOTA is ignored in OCIOSO.
- State ESPERA:
  - Timeout counter increments every cycle.
  - SENSOR_NOTA != 00 -> load the debounce counter with 1, capture the code, go to FILTRO.
  - Counter reaches TIMEOUT-1 -> go to EXPIRADO.
- State FILTRO:
  - Same code as captured -> increment the debounce counter. On reaching DEBOUNCE: CEDULA=captured code, TIMER=0, ENTREGA=1 on the next cycle, clear the timeout counter, go to RETIRADA.
  - Code changes to another nonzero value -> restart with the new code and count=1.
  - Code returns to 00 -> glitch; back to ESPERA. The timeout counter is not cleared.
  - The timeout counter keeps running in FILTRO; expiry takes priority over acceptance in the same cycle.
- State RETIRADA:
  - Wait for SENSOR_NOTA=00 for one cycle, then go to ESPERA. Guarantees one strobe per note.
  - The timeout counter runs here too.
- State EXPIRADO:
  - On entry, single strobe: ENTREGA=1, TIMER=1, CEDULA=00.
  - Then wait for SAIDA in {10,11}.
- Session end:
  - In any non-OCIOSO state, SAIDA in {10,11} sampled -> go to OCIOSO next cycle; PRODUTO=00, OCUPADO=0.
  - A pending debounce is discarded with no strobe.
  - SAIDA end takes priority over every other transition.
- Unrecognised notes: code 11 is delivered as CEDULA=11 like any other note. Rejection is the payment FSM's job.
- CONFIRMA edges while OCUPADO=1 are ignored; PRODUTO cannot change mid-session.
- Counters saturate and never wrap.
- Reset asserted mid-session aborts immediately to the reset values. No strobe is emitted on release.

Test Plan:
- Reset, SELECAO=11, CONFIRMA pulse -> PRODUTO=11 and OCUPADO=1 one cycle after the edge; CEDULA=00, ENTREGA=0.
- In ESPERA, SENSOR_NOTA=01 held 6 cycles then 00 -> exactly one ENTREGA with CEDULA=01, DEBOUNCE cycles after the code first appears; no second strobe.
- SENSOR_NOTA=10 for 2 cycles, then 00 (DEBOUNCE=4) -> no ENTREGA; timeout counter not cleared.
- No note for TIMEOUT cycles after the session opens (TIMEOUT=20 in bench) -> single ENTREGA with TIMER=1, CEDULA=00. Then SAIDA=10 -> OCIOSO, OCUPADO=0, PRODUTO=00.
- Five notes of 01, each 5 cycles with a 3-cycle gap -> five strobes of CEDULA=01. Then SAIDA=11 -> OCIOSO. A SENSOR_NOTA=01 in OCIOSO produces nothing.
- RST pulsed while in FILTRO at count 3 -> all outputs 0 immediately. After release, SENSOR_NOTA=01 produces no strobe until a new CONFIRMA.
